// File: rtl/eth_phy_10g_rx_lock_ctrl.sv
// 10GBASE-R receive bring-up sequencer: SERDES RX reset, PMA ready wait,
// block-lock qualification, link-up monitoring and bounded retry.
//   state      | meaning
//   IDLE       | disabled, SERDES and frame sync held in reset
//   SERDES_RST | SERDES RX reset pulse of RST_CYCLES
//   WAIT_READY | waiting for serdes_rx_ready, READY_TIMEOUT budget
//   SYNC       | frame sync running, qualifying block lock
//   UP         | link up, rx_status follows lock and BER
//   FAIL       | retries exhausted, held until enable drops
module eth_phy_10g_rx_lock_ctrl #(
    parameter int RST_CYCLES     = 16,
    parameter int READY_TIMEOUT  = 4096,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int QUALIFY_CYCLES = 64,
    parameter int MAX_RETRIES    = 3,
    parameter int TIMER_WIDTH    = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       serdes_rx_ready,
    input  logic       rx_block_lock,
    input  logic       rx_high_ber,
    output logic       serdes_rx_reset,
    output logic       frame_sync_rst,
    output logic       rx_status,
    output logic       lock_fail,
    output logic [3:0] retry_count
);

    localparam int QW = $clog2(QUALIFY_CYCLES + 1);

    localparam logic [TIMER_WIDTH-1:0] RST_LOAD   = TIMER_WIDTH'(RST_CYCLES - 1);
    localparam logic [TIMER_WIDTH-1:0] READY_LOAD = TIMER_WIDTH'(READY_TIMEOUT - 1);
    localparam logic [TIMER_WIDTH-1:0] LOCK_LOAD  = TIMER_WIDTH'(LOCK_TIMEOUT - 1);
    localparam logic [QW-1:0]          QUAL_TARGET = QW'(QUALIFY_CYCLES);
    localparam logic [3:0]             RETRY_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SERDES_RST = 3'd1,
        WAIT_READY = 3'd2,
        SYNC       = 3'd3,
        UP         = 3'd4,
        FAIL       = 3'd5
    } state_t;

    state_t                 state, state_nxt;
    logic [TIMER_WIDTH-1:0] timer, timer_nxt;
    logic [QW-1:0]          qual, qual_nxt, qual_inc;
    logic [3:0]             retry_nxt, retry_inc;
    logic                   retry_go;
    logic                   timer_zero;

    always_comb begin
        state_nxt  = state;
        timer_nxt  = timer;
        qual_nxt   = qual;
        retry_nxt  = retry_count;
        retry_go   = 1'b0;
        timer_zero = (timer == '0);
        qual_inc   = qual + QW'(1);
        retry_inc  = (retry_count == 4'hF) ? 4'hF : retry_count + 4'd1;

        if (!enable) begin
            state_nxt = IDLE;
            timer_nxt = '0;
            qual_nxt  = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_nxt = SERDES_RST;
                    timer_nxt = RST_LOAD;
                end
                SERDES_RST: begin
                    if (timer_zero) begin
                        state_nxt = WAIT_READY;
                        timer_nxt = READY_LOAD;
                    end else begin
                        timer_nxt = timer - TIMER_WIDTH'(1);
                    end
                end
                WAIT_READY: begin
                    if (serdes_rx_ready) begin
                        state_nxt = SYNC;
                        timer_nxt = LOCK_LOAD;
                        qual_nxt  = '0;
                    end else if (timer_zero) begin
                        retry_go = 1'b1;
                    end else begin
                        timer_nxt = timer - TIMER_WIDTH'(1);
                    end
                end
                SYNC: begin
                    // Losing PMA ready is a hard fault; a lock qualified on the
                    // expiry cycle still counts as success.
                    if (!serdes_rx_ready) begin
                        retry_go = 1'b1;
                    end else if (rx_block_lock && (qual_inc == QUAL_TARGET)) begin
                        state_nxt = UP;
                        qual_nxt  = '0;
                        retry_nxt = '0;
                    end else begin
                        qual_nxt = rx_block_lock ? qual_inc : '0;
                        if (timer_zero) begin
                            retry_go = 1'b1;
                        end else begin
                            timer_nxt = timer - TIMER_WIDTH'(1);
                        end
                    end
                end
                UP: begin
                    if (!serdes_rx_ready) begin
                        retry_go = 1'b1;
                    end else if (!rx_block_lock) begin
                        state_nxt = SYNC;
                        timer_nxt = LOCK_LOAD;
                        qual_nxt  = '0;
                    end
                end
                FAIL: begin
                end
                default: begin
                    state_nxt = IDLE;
                    timer_nxt = '0;
                    qual_nxt  = '0;
                end
            endcase

            if (retry_go) begin
                retry_nxt = retry_inc;
                qual_nxt  = '0;
                if (retry_inc == RETRY_LIMIT) begin
                    state_nxt = FAIL;
                    timer_nxt = '0;
                end else begin
                    state_nxt = SERDES_RST;
                    timer_nxt = RST_LOAD;
                end
            end
        end
    end

    // Outputs are decoded from the next state so they register alongside it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= IDLE;
            timer           <= '0;
            qual            <= '0;
            retry_count     <= '0;
            serdes_rx_reset <= 1'b1;
            frame_sync_rst  <= 1'b1;
            rx_status       <= 1'b0;
            lock_fail       <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            qual            <= qual_nxt;
            retry_count     <= retry_nxt;
            serdes_rx_reset <= (state_nxt == IDLE) || (state_nxt == SERDES_RST) ||
                               (state_nxt == FAIL);
            frame_sync_rst  <= !((state_nxt == SYNC) || (state_nxt == UP));
            rx_status       <= (state_nxt == UP) && rx_block_lock && !rx_high_ber;
            lock_fail       <= (state_nxt == FAIL);
        end
    end

endmodule

// File: tb/tb_eth_phy_10g_rx_lock_ctrl.sv
// Bench for the RX lock sequencer: directed bring-up scenarios with literal
// timing expectations, then randomized traffic against a phase-level model.
module tb_eth_phy_10g_rx_lock_ctrl;

    localparam int RC  = 16;
    localparam int RT  = 4096;
    localparam int LT  = 300;
    localparam int QC  = 64;
    localparam int MR  = 3;

    localparam int P_IDLE = 0, P_RST = 1, P_WAIT = 2, P_SYNC = 3, P_UP = 4, P_FAIL = 5;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       serdes_rx_ready;
    logic       rx_block_lock;
    logic       rx_high_ber;
    logic       serdes_rx_reset;
    logic       frame_sync_rst;
    logic       rx_status;
    logic       lock_fail;
    logic [3:0] retry_count;

    int n_checks = 0;
    int n_pass   = 0;

    eth_phy_10g_rx_lock_ctrl #(
        .RST_CYCLES(RC), .READY_TIMEOUT(RT), .LOCK_TIMEOUT(LT),
        .QUALIFY_CYCLES(QC), .MAX_RETRIES(MR), .TIMER_WIDTH(20)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .serdes_rx_ready(serdes_rx_ready), .rx_block_lock(rx_block_lock),
        .rx_high_ber(rx_high_ber), .serdes_rx_reset(serdes_rx_reset),
        .frame_sync_rst(frame_sync_rst), .rx_status(rx_status),
        .lock_fail(lock_fail), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Phase-level model: elapsed time in a phase counts up, run is the
    // current streak of consecutive lock cycles, attempts counts failures.
    int ph = P_IDLE, elapsed = 0, run = 0, attempts = 0;
    bit m_status = 1'b0;

    function automatic int m_srst();
        return (ph == P_IDLE || ph == P_RST || ph == P_FAIL) ? 1 : 0;
    endfunction
    function automatic int m_fsrst();
        return (ph == P_SYNC || ph == P_UP) ? 0 : 1;
    endfunction

    task automatic m_attempt_failed();
        attempts = (attempts < 15) ? attempts + 1 : 15;
        elapsed  = 0;
        run      = 0;
        ph       = (attempts == MR) ? P_FAIL : P_RST;
    endtask

    task automatic m_step(input bit e, input bit rdy, input bit lk, input bit ber);
        if (!e) begin
            ph = P_IDLE; attempts = 0; elapsed = 0; run = 0;
        end else begin
            case (ph)
                P_IDLE: begin ph = P_RST; elapsed = 0; end
                P_RST: begin
                    elapsed++;
                    if (elapsed == RC) begin ph = P_WAIT; elapsed = 0; end
                end
                P_WAIT: begin
                    elapsed++;
                    if (rdy) begin ph = P_SYNC; elapsed = 0; run = 0; end
                    else if (elapsed == RT) m_attempt_failed();
                end
                P_SYNC: begin
                    elapsed++;
                    if (!rdy) m_attempt_failed();
                    else begin
                        run = lk ? run + 1 : 0;
                        if (run == QC) begin ph = P_UP; attempts = 0; end
                        else if (elapsed == LT) m_attempt_failed();
                    end
                end
                P_UP: begin
                    if (!rdy) m_attempt_failed();
                    else if (!lk) begin ph = P_SYNC; elapsed = 0; run = 0; end
                end
                default: ;
            endcase
        end
        m_status = (ph == P_UP) && lk && !ber;
    endtask

    always @(posedge clk) begin
        #1;
        if (!rst_n) begin
            ph = P_IDLE; elapsed = 0; run = 0; attempts = 0; m_status = 1'b0;
        end else begin
            m_step(enable, serdes_rx_ready, rx_block_lock, rx_high_ber);
        end
        check("cmp_serdes_rx_reset", serdes_rx_reset, m_srst());
        check("cmp_frame_sync_rst", frame_sync_rst, m_fsrst());
        check("cmp_rx_status", rx_status, m_status);
        check("cmp_lock_fail", lock_fail, (ph == P_FAIL) ? 1 : 0);
        check("cmp_retry_count", retry_count, attempts);
    end

    int srst_len, fs_at, up_at, zeros, left_up, t1, t2, t3, tf, r1;
    bit srst_done;
    int drop_div;

    initial begin
        rst_n = 1'b0; enable = 1'b0; serdes_rx_ready = 1'b0;
        rx_block_lock = 1'b0; rx_high_ber = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_serdes_rx_reset", serdes_rx_reset, 1);
        check("rst_frame_sync_rst", frame_sync_rst, 1);
        check("rst_rx_status", rx_status, 0);
        check("rst_lock_fail", lock_fail, 0);
        check("rst_retry_count", retry_count, 0);

        // Nominal bring-up: ready 10 cycles after release, lock solid.
        enable = 1'b1; rx_block_lock = 1'b1; rst_n = 1'b1;
        srst_len = 0; srst_done = 1'b0; fs_at = -1; up_at = -1;
        for (int k = 1; k <= 200 && up_at < 0; k++) begin
            @(negedge clk);
            if (k == 10) serdes_rx_ready = 1'b1;
            if (!srst_done) begin
                if (serdes_rx_reset) srst_len++;
                else srst_done = 1'b1;
            end
            if (fs_at < 0 && !frame_sync_rst) fs_at = k;
            if (up_at < 0 && rx_status) up_at = k;
        end
        check("nominal_rst_pulse_len", srst_len, RC);
        check("nominal_sync_entry", fs_at, 18);
        check("nominal_sync_to_up", up_at - fs_at, QC);
        check("nominal_retry_count", retry_count, 0);
        check("model_pin_up", (ph == P_UP) ? 1 : 0, 1);

        // High BER in UP masks rx_status without leaving UP.
        rx_high_ber = 1'b1; zeros = 0; left_up = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!rx_status) zeros++;
            if (frame_sync_rst || serdes_rx_reset) left_up++;
        end
        rx_high_ber = 1'b0;
        @(negedge clk);
        check("ber_status_low_cycles", zeros, 100);
        check("ber_left_up", left_up, 0);
        check("ber_status_restored", rx_status, 1);

        // One-cycle lock loss: back to SYNC, SERDES untouched.
        rx_block_lock = 1'b0;
        @(negedge clk);
        rx_block_lock = 1'b1;
        check("relock_status", rx_status, 0);
        check("relock_no_serdes_rst", serdes_rx_reset, 0);
        check("relock_fs_running", frame_sync_rst, 0);

        // Lock glitch at SYNC cycle 40 restarts qualification.
        repeat (39) @(negedge clk);
        check("glitch_not_up_yet", rx_status, 0);
        rx_block_lock = 1'b0;
        @(negedge clk);
        rx_block_lock = 1'b1;
        up_at = -1; left_up = 0;
        for (int k = 1; k <= 100 && up_at < 0; k++) begin
            @(negedge clk);
            if (serdes_rx_reset) left_up++;
            if (rx_status) up_at = k;
        end
        check("glitch_relock_to_up", up_at, QC);
        check("glitch_no_serdes_rst", left_up, 0);

        // Ready never asserts: three READY_TIMEOUT expiries then FAIL.
        serdes_rx_ready = 1'b0; enable = 1'b0;
        @(negedge clk);
        enable = 1'b1;
        t1 = -1; t2 = -1; t3 = -1; tf = -1;
        for (int k = 1; k <= 13000 && tf < 0; k++) begin
            @(negedge clk);
            if (t1 < 0 && retry_count == 4'd1) t1 = k;
            if (t2 < 0 && retry_count == 4'd2) t2 = k;
            if (t3 < 0 && retry_count == 4'd3) t3 = k;
            if (tf < 0 && lock_fail) tf = k;
        end
        check("noready_retry1_at", t1, 1 + RC + RT);
        check("noready_retry2_gap", t2 - t1, RC + RT);
        check("noready_retry3_gap", t3 - t2, RC + RT);
        check("noready_fail_with_retry3", tf, t3);
        check("noready_fail_serdes_rst", serdes_rx_reset, 1);
        repeat (5) @(negedge clk);
        check("fail_held", lock_fail, 1);
        check("fail_retry_count", retry_count, MR);
        check("model_pin_fail", attempts, MR);

        // Exit FAIL through a one-cycle enable drop.
        enable = 1'b0;
        @(negedge clk);
        check("fail_exit_lock_fail", lock_fail, 0);
        check("fail_exit_retry_count", retry_count, 0);
        check("fail_exit_serdes_rst", serdes_rx_reset, 1);
        enable = 1'b1;
        srst_len = 0; srst_done = 1'b0;
        for (int k = 1; k <= 40 && !srst_done; k++) begin
            @(negedge clk);
            if (serdes_rx_reset) srst_len++;
            else srst_done = 1'b1;
        end
        check("restart_rst_pulse_len", srst_len, RC);

        // No lock in SYNC: LOCK_TIMEOUT expiry, then async reset mid-SYNC.
        serdes_rx_ready = 1'b1; rx_block_lock = 1'b0;
        fs_at = -1; r1 = -1;
        for (int k = 1; k <= 400 && r1 < 0; k++) begin
            @(negedge clk);
            if (fs_at < 0 && !frame_sync_rst) fs_at = k;
            if (r1 < 0 && retry_count == 4'd1) r1 = k;
        end
        check("lock_timeout_len", r1 - fs_at, LT);
        fs_at = -1;
        for (int k = 1; k <= 50 && fs_at < 0; k++) begin
            @(negedge clk);
            if (!frame_sync_rst) fs_at = k;
        end
        check("resync_after_retry", fs_at, RC + 1);
        repeat (5) @(negedge clk);
        check("pre_reset_retry_count", retry_count, 1);
        #2 rst_n = 1'b0;
        #1;
        check("async_serdes_rx_reset", serdes_rx_reset, 1);
        check("async_frame_sync_rst", frame_sync_rst, 1);
        check("async_rx_status", rx_status, 0);
        check("async_lock_fail", lock_fail, 0);
        check("async_retry_count", retry_count, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized traffic; lock quality alternates to exercise timeouts.
        drop_div = 200;
        for (int c = 0; c < 25000; c++) begin
            @(negedge clk);
            if (c % 3000 == 0) drop_div = ($urandom_range(1, 0) == 0) ? 200 : 20;
            if (enable) begin
                if ($urandom_range(2999, 0) == 0) enable = 1'b0;
            end else if ($urandom_range(2, 0) == 0) enable = 1'b1;
            if (serdes_rx_ready) begin
                if ($urandom_range(1499, 0) == 0) serdes_rx_ready = 1'b0;
            end else if ($urandom_range(49, 0) == 0) serdes_rx_ready = 1'b1;
            if (rx_block_lock) begin
                if ($urandom_range(drop_div - 1, 0) == 0) rx_block_lock = 1'b0;
            end else if ($urandom_range(3, 0) == 0) rx_block_lock = 1'b1;
            if ($urandom_range(19, 0) == 0) rx_high_ber = ~rx_high_ber;
            if ($urandom_range(7999, 0) == 0) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end

        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
